mod_mem_store_unit: RTL and testbench
=====================================

Name: mod_mem_store_unit

Overview:
Store-side counterpart to the load-path data aligner. It accepts a store request (funct3, byte address, rs2 value) from the memory stage. It generates word-aligned write data and byte enables, then drives one or two write beats to the data memory over a waitrequest-style bus. Misaligned SH/SW stores are optionally split into two aligned beats. Completion or error is reported back to the pipeline.

Parameters:
SPLIT_MISALIGNED, 1, 1: split word-crossing stores into two beats; 0: flag them as error with no memory write.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
req_valid_i  input  1  store request valid
req_ready_o  output  1  unit can accept a request (high only in IDLE)
funct3_i  input  `FUNCT3_WIDTH  store type: `FUNCT3_SB, `FUNCT3_SH, `FUNCT3_SW
address_unaligned_i  input  `XLEN  byte address of store
store_data_i  input  `XLEN  rs2 value (low bytes significant)
mem_write_o  output  1  write strobe to data memory
mem_address_o  output  `XLEN  word-aligned address (bits[1:0]=0)
mem_writedata_o  output  `XLEN  lane-shifted write data
mem_byteenable_o  output  4  per-byte write enable
mem_waitrequest_i  input  1  memory stall; beat accepted when mem_write_o && !mem_waitrequest_i
done_o  output  1  one-cycle pulse: request finished
error_o  output  1  valid with done_o: illegal funct3 or (SPLIT_MISALIGNED=0 and misaligned)

Behaviour:
- Reset (async, rst_i=1): state IDLE; mem_write_o=0, mem_address_o=0, mem_writedata_o=0, mem_byteenable_o=0, done_o=0, error_o=0; req_ready_o=1 once out of reset. Reset mid-beat aborts the store immediately; no further beats are issued.
- Accept: req_valid_i && req_ready_o at edge N; all inputs are registered.
- Lane computation: off=addr[1:0]; base_be = SB 4'b0001, SH 4'b0011, SW 4'b1111.
  - be64 = {4'b0,base_be} << off.
  - data64 = {32'b0, store_data_i masked to size} << (8*off).
  - Beat0 uses be64[3:0] and data64[31:0] at address {addr[31:2],2'b00}.
  - Beat1 is needed iff be64[7:4]!=0; it uses be64[7:4] and data64[63:32] at beat0 address + 4, wrapping modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000).
- States:
  - IDLE: on accept with legal, issuable request -> BEAT0. On illegal request -> RESP_ERR.
  - BEAT0: mem_write_o=1, outputs held stable while mem_waitrequest_i=1. On acceptance -> BEAT1 if split is needed, else RESP.
  - BEAT1: same hold rules as BEAT0. On acceptance -> RESP.
  - RESP: done_o=1, error_o=0, mem_write_o=0; -> IDLE next cycle.
  - RESP_ERR: done_o=1, error_o=1, no memory write ever issued; -> IDLE.
- Latency with no wait states: accept at N, beat0 at N+1, done_o at N+2. A split store puts beat1 at N+2 and done_o at N+3.
- Each wait-state cycle adds one cycle to the beat it stalls.
- No new request is accepted until the cycle after done_o (req_ready_o=0 in BEAT0/BEAT1/RESP/RESP_ERR).
- Illegal funct3 is any value other than SB/SH/SW. Illegal requests never assert mem_write_o.
- SB is never misaligned.
- SH at off=3 and SW at off!=0 are misaligned:
  - SPLIT_MISALIGNED=1: the store splits into two beats.
  - SPLIT_MISALIGNED=0: the request goes to RESP_ERR.
- mem_byteenable_o and mem_writedata_o are 0 whenever mem_write_o=0. Byte lanes with a deasserted enable carry 0.

Decomposition:
- Shared package/defines (system_defines.svh): `XLEN, `FUNCT3_WIDTH, `FUNCT3_SB/SH/SW, plus a new store_state_e enum (IDLE, BEAT0, BEAT1, RESP, RESP_ERR) and BYTE_EN_WIDTH=4.
- One natural combinational sub-module: mod_mem_store_lane_gen (funct3, off, data -> be64, data64, needs_split, illegal). It is reusable by the verification model.

Test Plan:
- SB addr 0x1003 data 0xAABBCCDD, no wait -> beat at N+1: addr 0x1000, be 4'b1000, wdata 0xDD000000; done_o at N+2, error_o=0.
- SH addr 0x2002 data 0x1234ABCD, mem_waitrequest_i=1 for 3 cycles -> outputs held stable for 3 cycles (addr 0x2000, be 4'b1100, wdata 0xABCD0000); done_o at N+5.
- SW addr 0x3001 data 0x11223344, SPLIT_MISALIGNED=1 -> beat0 addr 0x3000 be 4'b1110 wdata 0x22334400; beat1 addr 0x3004 be 4'b0001 wdata 0x00000011; done_o at N+3.
- SW addr 0xFFFFFFFE data 0xCAFEBABE -> beat0 addr 0xFFFFFFFC be 4'b1100 wdata 0xBABE0000; beat1 addr 0x00000000 be 4'b0011 wdata 0x0000CAFE.
- funct3=3'b011 addr 0x4000 -> no mem_write_o ever; done_o=1, error_o=1 at N+1. With SPLIT_MISALIGNED=0, SH addr 0x4003 -> same error response.
- rst_i asserted during BEAT0 stall -> mem_write_o=0 in the same cycle (async), req_ready_o=1 after release, and the next SW addr 0x5000 completes normally.

Source files
------------

// File: rtl/mod_mem_store_unit_pkg.sv
// rtl/mod_mem_store_unit_pkg.sv - shared widths, store funct3 codes and store FSM states
package mod_mem_store_unit_pkg;

    localparam int XLEN          = 32;
    localparam int FUNCT3_WIDTH  = 3;
    localparam int BYTE_EN_WIDTH = 4;

    localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SB = 3'b000;
    localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SH = 3'b001;
    localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SW = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BEAT0    = 3'd1,
        BEAT1    = 3'd2,
        RESP     = 3'd3,
        RESP_ERR = 3'd4
    } store_state_e;

endpackage

// File: rtl/mod_mem_store_lane_gen.sv
// rtl/mod_mem_store_lane_gen.sv - byte-lane placement of a store across a two-word window
module mod_mem_store_lane_gen
    import mod_mem_store_unit_pkg::*;
(
    input  logic [FUNCT3_WIDTH-1:0]    funct3_i,
    input  logic [1:0]                 off_i,
    input  logic [XLEN-1:0]            data_i,
    output logic [2*BYTE_EN_WIDTH-1:0] be64_o,
    output logic [2*XLEN-1:0]          data64_o,
    output logic                       needs_split_o,
    output logic                       illegal_o
);

    logic [BYTE_EN_WIDTH-1:0] base_be;
    logic [XLEN-1:0]          masked;

    always_comb begin
        base_be   = '0;
        masked    = '0;
        illegal_o = 1'b0;
        case (funct3_i)
            FUNCT3_SB: begin base_be = 4'b0001; masked = {24'b0, data_i[7:0]};  end
            FUNCT3_SH: begin base_be = 4'b0011; masked = {16'b0, data_i[15:0]}; end
            FUNCT3_SW: begin base_be = 4'b1111; masked = data_i;                end
            default:   illegal_o = 1'b1;
        endcase
    end

    // The upper half of the window is the word following the aligned address.
    assign be64_o        = {4'b0, base_be} << off_i;
    assign data64_o      = {32'b0, masked} << {off_i, 3'b000};
    assign needs_split_o = |be64_o[7:4];

endmodule

// File: rtl/mod_mem_store_unit.sv
// rtl/mod_mem_store_unit.sv - store unit issuing one or two aligned write beats per request
module mod_mem_store_unit
    import mod_mem_store_unit_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [FUNCT3_WIDTH-1:0]  funct3_i,
    input  logic [XLEN-1:0]          address_unaligned_i,
    input  logic [XLEN-1:0]          store_data_i,
    output logic                     mem_write_o,
    output logic [XLEN-1:0]          mem_address_o,
    output logic [XLEN-1:0]          mem_writedata_o,
    output logic [BYTE_EN_WIDTH-1:0] mem_byteenable_o,
    input  logic                     mem_waitrequest_i,
    output logic                     done_o,
    output logic                     error_o
);

    store_state_e               state_q, state_d;
    logic [XLEN-1:0]            addr_q, addr_d;
    logic [2*BYTE_EN_WIDTH-1:0] be_q, be_d;
    logic [2*XLEN-1:0]          data_q, data_d;

    logic [2*BYTE_EN_WIDTH-1:0] lane_be;
    logic [2*XLEN-1:0]          lane_data;
    logic                       lane_split;
    logic                       lane_illegal;

    mod_mem_store_lane_gen u_lane_gen (
        .funct3_i      (funct3_i),
        .off_i         (address_unaligned_i[1:0]),
        .data_i        (store_data_i),
        .be64_o        (lane_be),
        .data64_o      (lane_data),
        .needs_split_o (lane_split),
        .illegal_o     (lane_illegal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            data_q  <= data_d;
        end
    end

    // Bus outputs decode straight from state so an async reset drops the strobe at once.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        be_d             = be_q;
        data_d           = data_q;
        req_ready_o      = 1'b0;
        mem_write_o      = 1'b0;
        mem_address_o    = '0;
        mem_writedata_o  = '0;
        mem_byteenable_o = '0;
        done_o           = 1'b0;
        error_o          = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = !rst_i;
                if (req_valid_i && !rst_i) begin
                    addr_d = {address_unaligned_i[XLEN-1:2], 2'b00};
                    be_d   = lane_be;
                    data_d = lane_data;
                    if (lane_illegal || (lane_split && !SPLIT_MISALIGNED))
                        state_d = RESP_ERR;
                    else
                        state_d = BEAT0;
                end
            end
            BEAT0: begin
                mem_write_o      = 1'b1;
                mem_address_o    = addr_q;
                mem_byteenable_o = be_q[3:0];
                mem_writedata_o  = data_q[31:0];
                if (!mem_waitrequest_i)
                    state_d = (|be_q[7:4]) ? BEAT1 : RESP;
            end
            BEAT1: begin
                mem_write_o      = 1'b1;
                mem_address_o    = addr_q + 32'd4;
                mem_byteenable_o = be_q[7:4];
                mem_writedata_o  = data_q[63:32];
                if (!mem_waitrequest_i)
                    state_d = RESP;
            end
            RESP: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            RESP_ERR: begin
                done_o  = 1'b1;
                error_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mod_mem_store_unit.sv
// tb/tb_mod_mem_store_unit.sv - directed vector bench for the store unit
module tb_mod_mem_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_ns;
    logic [2:0]  funct3;
    logic [31:0] addr, data;
    logic        waitreq;

    logic        ready, wr, done, err;
    logic [31:0] maddr, wdata;
    logic [3:0]  be;
    logic        ready_ns, wr_ns, done_ns, err_ns;
    logic [31:0] maddr_ns, wdata_ns;
    logic [3:0]  be_ns;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mod_mem_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready),
        .funct3_i(funct3), .address_unaligned_i(addr), .store_data_i(data),
        .mem_write_o(wr), .mem_address_o(maddr), .mem_writedata_o(wdata),
        .mem_byteenable_o(be), .mem_waitrequest_i(waitreq),
        .done_o(done), .error_o(err)
    );

    mod_mem_store_unit #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_ns), .req_ready_o(ready_ns),
        .funct3_i(funct3), .address_unaligned_i(addr), .store_data_i(data),
        .mem_write_o(wr_ns), .mem_address_o(maddr_ns), .mem_writedata_o(wdata_ns),
        .mem_byteenable_o(be_ns), .mem_waitrequest_i(1'b0),
        .done_o(done_ns), .error_o(err_ns)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        split;
        logic        err;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        funct3 = v.f3; addr = v.addr; data = v.data; req_valid = 1'b1;
        chk("ready_idle", {31'b0, ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.err) begin
            chk("err_done", {31'b0, done}, 32'd1);
            chk("err_error", {31'b0, err}, 32'd1);
            chk("err_nowrite", {31'b0, wr}, 32'd0);
        end else begin
            chk("b0_write", {31'b0, wr}, 32'd1);
            chk("b0_addr", maddr, v.a0);
            chk("b0_be", {28'b0, be}, {28'b0, v.be0});
            chk("b0_wdata", wdata, v.wd0);
            chk("b0_notdone", {31'b0, done}, 32'd0);
            chk("b0_busy", {31'b0, ready}, 32'd0);
            if (v.split) begin
                @(negedge clk);
                chk("b1_write", {31'b0, wr}, 32'd1);
                chk("b1_addr", maddr, v.a1);
                chk("b1_be", {28'b0, be}, {28'b0, v.be1});
                chk("b1_wdata", wdata, v.wd1);
                chk("b1_notdone", {31'b0, done}, 32'd0);
            end
            @(negedge clk);
            chk("resp_done", {31'b0, done}, 32'd1);
            chk("resp_error", {31'b0, err}, 32'd0);
            chk("resp_nowrite", {31'b0, wr}, 32'd0);
            chk("resp_be_zero", {28'b0, be}, 32'd0);
            chk("resp_wd_zero", wdata, 32'd0);
        end
        @(negedge clk);
        chk("ready_after", {31'b0, ready}, 32'd1);
        chk("done_cleared", {31'b0, done}, 32'd0);
    endtask

    initial begin
        vec_t v;
        //          f3      addr          data          sp   er   a0            be0      wd0           a1            be1      wd1
        vecs[0]  = '{3'b000, 32'h0000_1003, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0000_1000, 4'b1000, 32'hDD000000, 32'h0,         4'b0000, 32'h0};
        vecs[1]  = '{3'b000, 32'h0000_1000, 32'h12345678, 1'b0, 1'b0, 32'h0000_1000, 4'b0001, 32'h00000078, 32'h0,         4'b0000, 32'h0};
        vecs[2]  = '{3'b000, 32'h0000_1002, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0000_1000, 4'b0100, 32'h00DD0000, 32'h0,         4'b0000, 32'h0};
        vecs[3]  = '{3'b001, 32'h0000_2000, 32'h1234ABCD, 1'b0, 1'b0, 32'h0000_2000, 4'b0011, 32'h0000ABCD, 32'h0,         4'b0000, 32'h0};
        vecs[4]  = '{3'b001, 32'h0000_2001, 32'h1234ABCD, 1'b0, 1'b0, 32'h0000_2000, 4'b0110, 32'h00ABCD00, 32'h0,         4'b0000, 32'h0};
        vecs[5]  = '{3'b001, 32'h0000_2003, 32'h1234ABCD, 1'b1, 1'b0, 32'h0000_2000, 4'b1000, 32'hCD000000, 32'h0000_2004, 4'b0001, 32'h000000AB};
        vecs[6]  = '{3'b010, 32'h0000_3000, 32'h11223344, 1'b0, 1'b0, 32'h0000_3000, 4'b1111, 32'h11223344, 32'h0,         4'b0000, 32'h0};
        vecs[7]  = '{3'b010, 32'h0000_3001, 32'h11223344, 1'b1, 1'b0, 32'h0000_3000, 4'b1110, 32'h22334400, 32'h0000_3004, 4'b0001, 32'h00000011};
        vecs[8]  = '{3'b010, 32'h0000_3003, 32'h11223344, 1'b1, 1'b0, 32'h0000_3000, 4'b1000, 32'h44000000, 32'h0000_3004, 4'b0111, 32'h00112233};
        vecs[9]  = '{3'b010, 32'hFFFF_FFFE, 32'hCAFEBABE, 1'b1, 1'b0, 32'hFFFF_FFFC, 4'b1100, 32'hBABE0000, 32'h0000_0000, 4'b0011, 32'h0000CAFE};
        vecs[10] = '{3'b011, 32'h0000_4000, 32'h55555555, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0,         4'b0000, 32'h0};
        vecs[11] = '{3'b100, 32'h0000_4001, 32'h55555555, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0,         4'b0000, 32'h0};

        rst = 1'b1; req_valid = 1'b0; req_valid_ns = 1'b0; waitreq = 1'b0;
        funct3 = 3'b000; addr = 32'h0; data = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_write", {31'b0, wr}, 32'd0);
        chk("rst_addr", maddr, 32'd0);
        chk("rst_be", {28'b0, be}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_done", {30'b0, done, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_out_of_reset", {31'b0, ready}, 32'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // SH with three wait-state cycles on the single beat.
        @(negedge clk);
        funct3 = 3'b001; addr = 32'h0000_2002; data = 32'h1234ABCD;
        req_valid = 1'b1; waitreq = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_write", {31'b0, wr}, 32'd1);
            chk("stall_addr", maddr, 32'h0000_2000);
            chk("stall_be", {28'b0, be}, 32'h0000_000C);
            chk("stall_wdata", wdata, 32'hABCD0000);
            chk("stall_notdone", {31'b0, done}, 32'd0);
            if (i == 3) waitreq = 1'b0;
            @(negedge clk);
        end
        chk("stall_done", {31'b0, done}, 32'd1);
        chk("stall_error", {31'b0, err}, 32'd0);
        @(negedge clk);

        // Reset asserted while the first beat is stalled.
        funct3 = 3'b010; addr = 32'h0000_5004; data = 32'hDEADBEEF;
        req_valid = 1'b1; waitreq = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_write", {31'b0, wr}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_write", {31'b0, wr}, 32'd0);
        chk("async_rst_be", {28'b0, be}, 32'd0);
        @(negedge clk);
        rst = 1'b0; waitreq = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, ready}, 32'd1);
        chk("post_rst_nowrite", {31'b0, wr}, 32'd0);
        v = '{3'b010, 32'h0000_5000, 32'h0BADF00D, 1'b0, 1'b0, 32'h0000_5000, 4'b1111, 32'h0BADF00D, 32'h0, 4'b0000, 32'h0};
        run_vec(v);

        // Non-splitting instance: misaligned SH errors, aligned SW still writes.
        @(negedge clk);
        funct3 = 3'b001; addr = 32'h0000_4003; data = 32'h0000BEEF;
        req_valid_ns = 1'b1;
        @(negedge clk);
        req_valid_ns = 1'b0;
        chk("ns_mis_done", {31'b0, done_ns}, 32'd1);
        chk("ns_mis_error", {31'b0, err_ns}, 32'd1);
        chk("ns_mis_nowrite", {31'b0, wr_ns}, 32'd0);
        chk("ns_mis_busy", {31'b0, ready_ns}, 32'd0);
        @(negedge clk);
        chk("ns_ready_after", {31'b0, ready_ns}, 32'd1);
        funct3 = 3'b010; addr = 32'h0000_4000; data = 32'h76543210;
        req_valid_ns = 1'b1;
        @(negedge clk);
        req_valid_ns = 1'b0;
        chk("ns_al_write", {31'b0, wr_ns}, 32'd1);
        chk("ns_al_addr", maddr_ns, 32'h0000_4000);
        chk("ns_al_be", {28'b0, be_ns}, 32'h0000_000F);
        chk("ns_al_wdata", wdata_ns, 32'h76543210);
        @(negedge clk);
        chk("ns_al_done", {31'b0, done_ns}, 32'd1);
        chk("ns_al_error", {31'b0, err_ns}, 32'd0);
        chk("main_idle_untouched", {31'b0, wr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
